// File: rtl/regfile_bypass_if.sv
// Decode/writeback-side signal bundle for regfile_bypass: two read ports,
// one byte-enabled write port, the reservation strobe and busy flags.
interface regfile_bypass_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic [AW-1:0]   Rn1;
  logic [AW-1:0]   Rn2;
  logic [DW-1:0]   A;
  logic [DW-1:0]   B;
  logic [AW-1:0]   Wn;
  logic            Write;
  logic [DW-1:0]   Wd;
  logic [DW/8-1:0] Wbe;
  logic            Rsv;
  logic [AW-1:0]   Rsvn;
  logic            Busy1;
  logic            Busy2;

  modport master (
    output Rn1, Rn2, Wn, Write, Wd, Wbe, Rsv, Rsvn,
    input  A, B, Busy1, Busy2
  );

  modport slave (
    input  Rn1, Rn2, Wn, Write, Wd, Wbe, Rsv, Rsvn,
    output A, B, Busy1, Busy2
  );
endinterface

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with byte-enabled writes, optional
// hardwired zero register, same-cycle write forwarding and a busy scoreboard.
module regfile_bypass #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic          Clock,
  input  logic          Reset,
  regfile_bypass_if.slave rf
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned NB    = DW / 8;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             wr_en;
  logic             rsv_en;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_en  = rf.Write && !is_zero(rf.Wn);
  assign rsv_en = rf.Rsv && !is_zero(rf.Rsvn);

  // Reservation is applied after the write clear so a same-register set wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[rf.Wn]   = 1'b0;
    if (rsv_en) busy_d[rf.Rsvn] = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_q <= '0;
      regs_q <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      if (wr_en) regs_q[rf.Wn] <= merge_bytes(regs_q[rf.Wn], rf.Wd, rf.Wbe);
    end
  end

  // Returns {busy, data}; a forwarded port shows the post-edge register state.
  function automatic logic [DW:0] read_port(input logic [AW-1:0] rn);
    logic          hit;
    logic [DW:0]   r;
    hit = (BYPASS != 0) && wr_en && (rf.Wn == rn);
    if (Reset || is_zero(rn))
      r = '0;
    else if (hit)
      r = {busy_d[rn], merge_bytes(regs_q[rn], rf.Wd, rf.Wbe)};
    else
      r = {busy_q[rn], regs_q[rn]};
    return r;
  endfunction

  always_comb begin
    {rf.Busy1, rf.A} = read_port(rf.Rn1);
    {rf.Busy2, rf.B} = read_port(rf.Rn2);
  end
endmodule

// File: tb/tb_regfile_bypass.sv
// Randomised scoreboard bench for regfile_bypass: a default instance and a
// small AW=3/DW=16 instance without bypass or zero register, same stimulus.
module tb_regfile_bypass;
  logic clk;
  logic rst;

  logic        st_write, st_rsv;
  logic [31:0] st_wn, st_wd, st_rsvn, st_rn1, st_rn2;
  logic [3:0]  st_wbe;

  regfile_bypass_if #(.DW(32), .AW(5)) if0 ();
  regfile_bypass_if #(.DW(16), .AW(3)) if1 ();

  assign if0.Rn1   = st_rn1[4:0];
  assign if0.Rn2   = st_rn2[4:0];
  assign if0.Wn    = st_wn[4:0];
  assign if0.Rsvn  = st_rsvn[4:0];
  assign if0.Write = st_write;
  assign if0.Rsv   = st_rsv;
  assign if0.Wd    = st_wd;
  assign if0.Wbe   = st_wbe;

  assign if1.Rn1   = st_rn1[2:0];
  assign if1.Rn2   = st_rn2[2:0];
  assign if1.Wn    = st_wn[2:0];
  assign if1.Rsvn  = st_rsvn[2:0];
  assign if1.Write = st_write;
  assign if1.Rsv   = st_rsv;
  assign if1.Wd    = st_wd[15:0];
  assign if1.Wbe   = st_wbe[1:0];

  regfile_bypass #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .Clock(clk), .Reset(rst), .rf(if0.slave));
  regfile_bypass #(.DW(16), .AW(3), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .Clock(clk), .Reset(rst), .rf(if1.slave));

  logic [1:0][31:0] ga, gb;
  logic [1:0]       gu1, gu2;
  assign ga[0] = if0.A;
  assign gb[0] = if0.B;
  assign ga[1] = {16'h0, if1.A};
  assign gb[1] = {16'h0, if1.B};
  assign gu1   = {if1.Busy1, if0.Busy1};
  assign gu2   = {if1.Busy2, if0.Busy2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain per-configuration arrays.
  int          cfg_aw  [2] = '{5, 3};
  int          cfg_dw  [2] = '{32, 16};
  bit          cfg_byp [2] = '{1'b1, 1'b0};
  bit          cfg_zr  [2] = '{1'b1, 1'b0};
  logic [31:0] mem [2][32];
  bit          bsy [2][32];

  typedef struct {
    logic [1:0][31:0] ea;
    logic [1:0][31:0] eb;
    logic [1:0]       eu1;
    logic [1:0]       eu2;
    string            tag;
  } exp_t;
  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int amask(int c, logic [31:0] a);
    return int'(a) & ((1 << cfg_aw[c]) - 1);
  endfunction

  function automatic logic [31:0] dmask(int c, logic [31:0] d);
    return (cfg_dw[c] == 32) ? d : (d & 32'h0000FFFF);
  endfunction

  function automatic bit wr_eff(int c);
    return st_write && !rst && !(cfg_zr[c] && amask(c, st_wn) == 0);
  endfunction

  function automatic bit rsv_eff(int c);
    return st_rsv && !rst && !(cfg_zr[c] && amask(c, st_rsvn) == 0);
  endfunction

  function automatic logic [31:0] nxt_data(int c, int a);
    logic [31:0] v;
    logic [31:0] w;
    v = mem[c][a];
    w = dmask(c, st_wd);
    if (wr_eff(c) && amask(c, st_wn) == a)
      for (int i = 0; i < cfg_dw[c] / 8; i++)
        if (st_wbe[i]) v[8*i +: 8] = w[8*i +: 8];
    return v;
  endfunction

  function automatic bit nxt_busy(int c, int a);
    bit b;
    b = bsy[c][a];
    if (wr_eff(c) && amask(c, st_wn) == a) b = 1'b0;
    if (rsv_eff(c) && amask(c, st_rsvn) == a) b = 1'b1;
    return b;
  endfunction

  task automatic exp_port(input int c, input logic [31:0] rn,
                          output logic [31:0] d, output logic b);
    int a;
    a = amask(c, rn);
    if (rst || (cfg_zr[c] && a == 0)) begin
      d = '0; b = 1'b0;
    end else if (cfg_byp[c] && wr_eff(c) && amask(c, st_wn) == a) begin
      d = nxt_data(c, a); b = nxt_busy(c, a);
    end else begin
      d = mem[c][a]; b = bsy[c][a];
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 32; a++) begin
        mem[c][a] = '0;
        bsy[c][a] = 1'b0;
      end
  endtask

  task automatic model_edge();
    logic [31:0] tm [2][32];
    bit          tb [2][32];
    if (rst) begin
      model_clear();
    end else begin
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 32; a++) begin
          tm[c][a] = (a < (1 << cfg_aw[c])) ? nxt_data(c, a) : mem[c][a];
          tb[c][a] = (a < (1 << cfg_aw[c])) ? nxt_busy(c, a) : bsy[c][a];
        end
      mem = tm;
      bsy = tb;
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    logic [31:0] d;
    logic        b;
    for (int c = 0; c < 2; c++) begin
      exp_port(c, st_rn1, d, b); e.ea[c] = d; e.eu1[c] = b;
      exp_port(c, st_rn2, d, b); e.eb[c] = d; e.eu2[c] = b;
    end
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic drive(input bit w, input logic [31:0] wn, input logic [31:0] wd,
                       input logic [3:0] be, input bit rv, input logic [31:0] rvn,
                       input logic [31:0] r1, input logic [31:0] r2, input string tag);
    @(posedge clk);
    model_edge();
    #1;
    st_write = w; st_wn = wn; st_wd = wd; st_wbe = be;
    st_rsv = rv; st_rsvn = rvn; st_rn1 = r1; st_rn2 = r2;
    push_exp(tag);
  endtask

  // Raise Reset after an edge, check while high, drop it before the next edge.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b1;
    model_clear();
    push_exp(tag);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int c = 0; c < 2; c++) begin
          n_tests++;
          if (ga[c] !== e.ea[c] || gb[c] !== e.eb[c] ||
              gu1[c] !== e.eu1[c] || gu2[c] !== e.eu2[c]) begin
            n_fail++;
            $display("FAIL %s dut%0d: got A=%h B=%h Busy1=%b Busy2=%b, expected A=%h B=%h Busy1=%b Busy2=%b",
                     e.tag, c, ga[c], gb[c], gu1[c], gu2[c],
                     e.ea[c], e.eb[c], e.eu1[c], e.eu2[c]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    st_write = 0; st_rsv = 0; st_wn = 0; st_wd = 0; st_wbe = 0;
    st_rsvn = 0; st_rn1 = 0; st_rn2 = 0;
    model_clear();

    drive(0, 0, 0, 4'h0, 0, 0, 1, 2, "rst_hold");
    drive(1, 1, 32'hFFFFFFFF, 4'hF, 1, 4, 1, 4, "rst_wr_block");
    drive(0, 0, 0, 4'h0, 0, 0, 1, 4, "rst_hold2");
    @(negedge clk); #1; rst = 1'b0;
    drive(0, 0, 0, 4'h0, 0, 0, 1, 4, "rst_released");

    drive(1, 1, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 1, "wr_full");
    drive(0, 0, 0, 4'h0, 0, 0, 1, 1, "rd_full");
    drive(1, 1, 32'h00000000, 4'b0010, 0, 0, 1, 0, "wr_be");
    drive(0, 0, 0, 4'h0, 0, 0, 1, 1, "rd_be");
    drive(1, 1, 32'h0, 4'h0, 0, 0, 1, 1, "wr_no_be");
    pulse_reset("rst_pulse");
    drive(0, 0, 0, 4'h0, 0, 0, 1, 1, "rst_pulse_after");

    drive(1, 0, 32'h12345678, 4'hF, 1, 0, 0, 0, "zero_wr");
    drive(0, 0, 0, 4'h0, 0, 0, 0, 0, "zero_rd");

    drive(1, 2, 32'hAAAAAAAA, 4'hF, 0, 0, 0, 0, "fill2");
    drive(1, 2, 32'h00000055, 4'b0001, 0, 0, 2, 2, "bypass2");
    drive(0, 0, 0, 4'h0, 0, 0, 2, 2, "after_bypass2");

    drive(0, 0, 0, 4'h0, 1, 3, 3, 3, "rsv3");
    drive(0, 0, 0, 4'h0, 1, 3, 3, 5, "busy3");
    drive(0, 0, 0, 4'h0, 0, 0, 3, 3, "busy3_again");
    drive(1, 3, 32'h77, 4'hF, 0, 0, 3, 3, "wr3_bypass");
    drive(0, 0, 0, 4'h0, 0, 0, 3, 3, "busy3_clr");
    drive(1, 3, 32'h88, 4'hF, 1, 3, 3, 3, "rsv_wr3");
    drive(0, 0, 0, 4'h0, 0, 0, 3, 3, "busy3_set");

    for (int i = 0; i < 32; i++)
      drive(1, i, i, 4'hF, 0, 0, i, (i + 1) % 32, "sweep_wr");
    for (int i = 0; i < 32; i++)
      drive(0, 0, 0, 4'h0, 0, 0, i, (i * 7 + 3) % 32, "sweep_rd");
    for (int i = 0; i < 32; i++)
      drive(0, 0, 0, 4'h0, 0, 0, i, i, "sweep_same");

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 59) == 0)
        pulse_reset("rnd_rst");
      else
        drive($urandom_range(0, 1), $urandom_range(0, 9), $urandom,
              4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
              $urandom_range(0, 9), $urandom_range(0, 9),
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31))
                                          : 32'($urandom_range(0, 9)),
              "random");
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Parametrised two-read/one-write register file for the pipelined datapath, succeeding the fixed 32×32 register file. Adds asynchronous reset, byte-enabled writes, optional hardwired-zero register 0, same-cycle write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets the decode stage detect pending writes before issuing an instruction. It sits between decode (reads, reservations) and writeback (writes).

## Interface
Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 5, address width; depth = 2^AW registers.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a write in the current cycle is forwarded to matching read ports.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- Rn1  in  AW  read address, port A.
- Rn2  in  AW  read address, port B.
- A  out  DW  read data for Rn1.
- B  out  DW  read data for Rn2.
- Wn  in  AW  write address.
- Write  in  1  write strobe.
- Wd  in  DW  write data.
- Wbe  in  DW/8  byte enables; bit i covers Wd[8i+7:8i].
- Rsv  in  1  reserve strobe; marks register Rsvn busy.
- Rsvn  in  AW  register to reserve.
- Busy1  out  1  Rn1 has a pending write.
- Busy2  out  1  Rn2 has a pending write.

## Operation
- Storage: 2^AW × DW registers plus 2^AW busy bits.
- Write: on a rising Clock edge with Write=1, each byte i of reg[Wn] with Wbe[i]=1 takes the matching Wd byte; other bytes hold. Write=1 with Wbe=0 changes no data but still clears busy.
- Busy update, same rising edge:
  - Write=1 clears busy[Wn].
  - Rsv=1 sets busy[Rsvn].
  - If Rsv and Write target the same register, the set wins and busy stays 1.
- Zero register (ZERO_REG=1): writes and reservations to address 0 are ignored; A/B read 0 and Busy1/Busy2 read 0 at address 0.
- Read: A and B are combinational from Rn1/Rn2 and register state; there is no read enable.
- Bypass (BYPASS=1): when Write=1, Wn==Rn1 and Rn1 is not the zero register:
  - A = the merged value, i.e. Wd bytes where Wbe=1, stored bytes elsewhere.
  - Busy1 = 0 unless Rsv=1 with Rsvn==Rn1 in the same cycle.
  - Port B behaves identically against Rn2.
- BYPASS=0: A, B, Busy1 and Busy2 show stored state only.
- Rn1 == Rn2 is legal; both ports return identical values.

## Timing
- Reset asserted: all registers and busy bits become 0 immediately, without waiting for a clock. While Reset is high, A=B=0 and Busy1=Busy2=0 for any address, and writes and reservations are blocked.
- Reset released mid-write: no write occurs on an edge where Reset is high.
- Read latency: 0 cycles (combinational).
- Write visibility: stored value is visible on the cycle after the edge; with BYPASS=1 it is also visible in the write cycle itself.
- Busy set by Rsv at edge N is visible from cycle N+1. The scoreboard has no reservation count: a second Rsv on an already-busy register is idempotent, and one write clears it.

## Test plan
- Reset: write 32'hFFFFFFFF to reg 1, then pulse Reset between clock edges -> A=0 immediately with Rn1=1, and stays 0 after Reset falls.
- Write/read: Wn=1, Write=1, Wbe=4'hF, Wd=32'hFFFFFFFF, then Write=0, Rn1=1 -> A=32'hFFFFFFFF. Then Wbe=4'b0010, Wd=32'h00000000 -> A=32'hFFFF00FF next cycle.
- Zero register (ZERO_REG=1): write 32'h12345678 to reg 0 with Rsv=1, Rsvn=0 -> A=0 and Busy1=0 with Rn1=0.
- Bypass: reg 2 holds 32'hAAAAAAAA; in one cycle set Write=1, Wn=2, Wbe=4'b0001, Wd=32'h55, Rn1=Rn2=2 -> A=B=32'hAAAAAA55 before the edge. Repeat with BYPASS=0 -> A=32'hAAAAAAAA before the edge.
- Scoreboard:
  - Rsv at reg 3 -> Busy1=1 next cycle (Rn1=3).
  - Write to reg 3 -> Busy1=0 during the write cycle (bypass), and busy stored 0 afterward.
  - Simultaneous Rsv and Write to reg 3 -> Busy1=1 after the edge.
- Dual port/depth sweep, AW=3, DW=16: write value i to every register i -> A and B read back i at all addresses; Rn1=Rn2 returns identical values.
